// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite register responder.
// Response codes, held write-beat record and byte-strobe merge.
package axil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  strb;
  } wbeat_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_dat,
                                             input logic [31:0] new_dat,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_dat;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_dat[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// DEPTH x 32 register file: byte-enable write on the clock, combinational read, reg0 tap.
// Write lands on the enabling edge; no backpressure, the caller owns sequencing.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW_IDX = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW_IDX-1:0] wr_idx,
  input  logic [31:0]       wr_dat,
  input  logic [3:0]        wr_strb,
  input  logic [AW_IDX-1:0] rd_idx,
  output logic [31:0]       rd_dat,
  output logic [31:0]       reg0_dat
);

  logic [31:0] regs [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= byte_merge(regs[wr_idx], wr_dat, wr_strb);
    end
  end

  // Read sees the pre-edge contents, so a same-edge read gets the old value.
  assign rd_dat   = regs[rd_idx];
  assign reg0_dat = regs[0];

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder over a DEPTH-register bank; DECERR outside the bank.
// Write commits 1 edge after both AW and W are held, read answers 1 edge after AR; B/R stall on BREADY/RREADY.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [WIDTH-1:0]   AWADDR,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic [WIDTH-1:0]   WDATA,
  input  logic [WIDTH/8-1:0] WSTRB,
  input  logic               WVALID,
  output logic               WREADY,
  output logic [1:0]         BRESP,
  output logic               BVALID,
  input  logic               BREADY,
  input  logic [WIDTH-1:0]   ARADDR,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [WIDTH-1:0]   RDATA,
  output logic [1:0]         RRESP,
  output logic               RVALID,
  input  logic               RREADY,
  output logic [WIDTH-1:0]   reg0_out
);

  localparam int AW_IDX = $clog2(DEPTH);

  function automatic logic addr_mapped(input logic [WIDTH-1:0] addr);
    return addr[WIDTH-1:AW_IDX+2] == '0;
  endfunction

  logic              aw_held;
  logic              aw_map_q;
  logic [AW_IDX-1:0] aw_idx_q;
  logic              w_held;
  wbeat_t            w_beat_q;
  logic              b_vld;
  resp_t             b_resp;
  logic              r_vld;
  logic [WIDTH-1:0]  r_dat;
  resp_t             r_resp;
  logic [31:0]       bank_rd_dat;
  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic              unused_addr_lsb;

  assign aw_hs  = AWVALID && !aw_held;
  assign w_hs   = WVALID && !w_held;
  assign ar_hs  = ARVALID && !r_vld;
  assign commit = aw_held && w_held && !b_vld;

  // Byte lane within a word never affects decode.
  assign unused_addr_lsb = &{1'b0, AWADDR[1:0], ARADDR[1:0]};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held  <= 1'b0;
      aw_map_q <= 1'b0;
      aw_idx_q <= '0;
    end else if (aw_hs) begin
      aw_held  <= 1'b1;
      aw_map_q <= addr_mapped(AWADDR);
      aw_idx_q <= AWADDR[AW_IDX+1:2];
    end else if (commit) begin
      aw_held  <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_held   <= 1'b0;
      w_beat_q <= '0;
    end else if (w_hs) begin
      w_held   <= 1'b1;
      w_beat_q <= '{dat: WDATA, strb: WSTRB};
    end else if (commit) begin
      w_held   <= 1'b0;
    end
  end

  // commit requires !b_vld, so it never overlaps the B handshake.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      b_vld  <= 1'b0;
      b_resp <= RESP_OKAY;
    end else if (commit) begin
      b_vld  <= 1'b1;
      b_resp <= aw_map_q ? RESP_OKAY : RESP_DECERR;
    end else if (b_vld && BREADY) begin
      b_vld  <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_vld  <= 1'b0;
      r_dat  <= '0;
      r_resp <= RESP_OKAY;
    end else if (ar_hs) begin
      r_vld  <= 1'b1;
      r_dat  <= addr_mapped(ARADDR) ? bank_rd_dat : '0;
      r_resp <= addr_mapped(ARADDR) ? RESP_OKAY : RESP_DECERR;
    end else if (r_vld && RREADY) begin
      r_vld  <= 1'b0;
    end
  end

  axil_reg_bank #(
    .DEPTH (DEPTH)
  ) u_bank (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .wr_en    (commit && aw_map_q),
    .wr_idx   (aw_idx_q),
    .wr_dat   (w_beat_q.dat),
    .wr_strb  (w_beat_q.strb),
    .rd_idx   (ARADDR[AW_IDX+1:2]),
    .rd_dat   (bank_rd_dat),
    .reg0_dat (reg0_out)
  );

  assign AWREADY = !aw_held;
  assign WREADY  = !w_held;
  assign BVALID  = b_vld;
  assign BRESP   = b_resp;
  assign ARREADY = !r_vld;
  assign RVALID  = r_vld;
  assign RDATA   = r_dat;
  assign RRESP   = r_resp;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: vector table, timed corner sequences, randomized traffic vs. an array model.
module tb_axil_reg_slave;

  localparam int DEPTH = 8;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] reg0_out;

  int tests = 0;
  int fails = 0;

  logic [31:0] model [DEPTH];

  axil_reg_slave #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .AWADDR   (AWADDR),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BRESP    (BRESP),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .ARADDR   (ARADDR),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .reg0_out (reg0_out)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: the register file is a plain array of words, byte-addressed.
  function automatic bit model_mapped(input logic [31:0] addr);
    return addr < 32'(4 * DEPTH);
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    if (!model_mapped(addr)) return;
    idx = int'(addr / 4);
    for (int b = 0; b < 4; b++)
      if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    int  cyc;
    bit  aw_done, w_done, aw_fire, w_fire, got;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    aw_done = 0; w_done = 0; cyc = 0; resp = 2'bxx;
    while (!(aw_done && w_done) && cyc < 100) begin
      AWVALID = !aw_done && (cyc >= aw_dly);
      WVALID  = !w_done && (cyc >= w_dly);
      @(negedge ACLK);
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      step();
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
      cyc++;
    end
    AWVALID = 0; WVALID = 0;
    check("wr_addr_data_accept", 32'(aw_done && w_done), 32'd1);
    cyc = 0; got = 0;
    while (!got && cyc < 100) begin
      BREADY = (cyc >= b_dly);
      @(negedge ACLK);
      if (BVALID && BREADY) begin
        resp = BRESP;
        got = 1;
      end
      step();
      cyc++;
    end
    BREADY = 0;
    check("wr_bresp_arrived", 32'(got), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    bit done, fire, got;
    ARADDR = addr; done = 0; cyc = 0; data = 'x; resp = 'x;
    while (!done && cyc < 100) begin
      ARVALID = (cyc >= ar_dly);
      @(negedge ACLK);
      fire = ARVALID && ARREADY;
      step();
      if (fire) done = 1;
      cyc++;
    end
    ARVALID = 0;
    check("rd_addr_accept", 32'(done), 32'd1);
    cyc = 0; got = 0;
    while (!got && cyc < 100) begin
      RREADY = (cyc >= r_dly);
      @(negedge ACLK);
      if (RVALID && RREADY) begin
        data = RDATA;
        resp = RRESP;
        got = 1;
      end
      step();
      cyc++;
    end
    RREADY = 0;
    check("rd_data_arrived", 32'(got), 32'd1);
  endtask

  task automatic check_all_regs(input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    for (int i = 0; i < DEPTH; i++) begin
      do_read(32'(i * 4), 0, 0, d, r);
      check({tag, "_rdata"}, d, model[i]);
      check({tag, "_rresp"}, 32'(r), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 32'(AWREADY), 32'd1);
    check({tag, "_wready"},  32'(WREADY),  32'd1);
    check({tag, "_bvalid"},  32'(BVALID),  32'd0);
    check({tag, "_rvalid"},  32'(RVALID),  32'd0);
    check({tag, "_bresp"},   32'(BRESP),   32'd0);
    check({tag, "_rresp"},   32'(RRESP),   32'd0);
    check({tag, "_rdata"},   RDATA,        32'd0);
    check({tag, "_reg0"},    reg0_out,     32'd0);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] addr, data;
    logic [3:0]  strb;

    ARESETn = 0;
    AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARVALID = 0; RREADY = 0;
    model_clear();

    vecs[0]  = '{1, 32'h04,       32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{0, 32'h04,       32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1, 32'h08,       32'h11223344, 4'hF, 2'b00, 32'h0};
    vecs[3]  = '{1, 32'h08,       32'h00FF0000, 4'h4, 2'b00, 32'h0};
    vecs[4]  = '{0, 32'h08,       32'h0,        4'h0, 2'b00, 32'h11FF3344};
    vecs[5]  = '{1, 32'h40,       32'h12345678, 4'hF, 2'b11, 32'h0};
    vecs[6]  = '{0, 32'h40,       32'h0,        4'h0, 2'b11, 32'h0};
    vecs[7]  = '{1, 32'h0C,       32'hAAAAAAAA, 4'h0, 2'b00, 32'h0};
    vecs[8]  = '{0, 32'h0C,       32'h0,        4'h0, 2'b00, 32'h0};
    vecs[9]  = '{0, 32'h07,       32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[10] = '{1, 32'h8000001C, 32'h99999999, 4'hF, 2'b11, 32'h0};
    vecs[11] = '{0, 32'h1C,       32'h0,        4'h0, 2'b00, 32'h0};
    vecs[12] = '{1, 32'h1F,       32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
    vecs[13] = '{0, 32'h1C,       32'h0,        4'h0, 2'b00, 32'hCAFEF00D};

    repeat (2) step();
    check_reset_outputs("reset");
    @(negedge ACLK);
    ARESETn = 1;
    step();
    check_all_regs("reset_regs");

    // AW and W together: handshake on edge n, B visible after edge n+1.
    AWADDR = 32'h04; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1; BREADY = 1;
    step();
    AWVALID = 0; WVALID = 0;
    check("lat_awready_held", 32'(AWREADY), 32'd0);
    check("lat_wready_held",  32'(WREADY),  32'd0);
    check("lat_bvalid_n",     32'(BVALID),  32'd0);
    step();
    check("lat_bvalid_n1",    32'(BVALID),  32'd1);
    check("lat_bresp",        32'(BRESP),   32'd0);
    step();
    check("lat_bvalid_clr",   32'(BVALID),  32'd0);
    BREADY = 0;
    model_write(32'h04, 32'hDEADBEEF, 4'hF);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, r);
        check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
        model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end else begin
        do_read(vecs[i].addr, 0, 0, d, r);
        check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      end
    end

    // W three cycles ahead of AW; partial strobe into reg0.
    do_write(32'h00, 32'h55667788, 4'hF, 0, 0, 0, r);
    model_write(32'h00, 32'h55667788, 4'hF);
    WDATA = 32'h000000AA; WSTRB = 4'h1; WVALID = 1;
    step();
    WVALID = 0;
    check("wfirst_wready_drop", 32'(WREADY), 32'd0);
    repeat (3) step();
    check("wfirst_no_commit", 32'(BVALID), 32'd0);
    check("wfirst_reg0_old",  reg0_out,    32'h55667788);
    AWADDR = 32'h00; AWVALID = 1; BREADY = 1;
    step();
    AWVALID = 0;
    check("wfirst_bvalid_n",  32'(BVALID), 32'd0);
    step();
    check("wfirst_bvalid_n1", 32'(BVALID), 32'd1);
    check("wfirst_reg0_new",  reg0_out,    32'h556677AA);
    step();
    BREADY = 0;
    model_write(32'h00, 32'h000000AA, 4'h1);

    // B stalled for several cycles while a second AW/W pair waits in the held slots.
    AWADDR = 32'h04; WDATA = 32'h0BADF00D; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    step();
    AWVALID = 0; WVALID = 0;
    step();
    check("bhold_bvalid_first", 32'(BVALID), 32'd1);
    AWADDR = 32'h50; WDATA = 32'h13579BDF; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    step();
    AWVALID = 0; WVALID = 0;
    check("bhold_aw_held", 32'(AWREADY), 32'd0);
    check("bhold_w_held",  32'(WREADY),  32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("bhold_bvalid_c%0d", c), 32'(BVALID), 32'd1);
      check($sformatf("bhold_bresp_c%0d", c),  32'(BRESP),  32'd0);
    end
    model_write(32'h04, 32'h0BADF00D, 4'hF);
    BREADY = 1;
    step();
    check("bhold_bvalid_clr", 32'(BVALID), 32'd0);
    step();
    check("bhold_bvalid_second", 32'(BVALID), 32'd1);
    check("bhold_bresp_second",  32'(BRESP),  32'd3);
    step();
    BREADY = 0;
    check_all_regs("bhold_regs");

    // Read and write commit to the same register on one edge: read gets the old value.
    do_write(32'h0C, 32'h01010101, 4'hF, 0, 0, 0, r);
    model_write(32'h0C, 32'h01010101, 4'hF);
    AWADDR = 32'h0C; WDATA = 32'hF0F0F0F0; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 1;
    step();
    AWVALID = 0; WVALID = 0; ARADDR = 32'h0C; ARVALID = 1;
    step();
    ARVALID = 0;
    check("same_rvalid",  32'(RVALID),  32'd1);
    check("same_arready", 32'(ARREADY), 32'd0);
    check("same_rdata",   RDATA,        32'h01010101);
    check("same_bvalid",  32'(BVALID),  32'd1);
    RREADY = 1;
    step();
    check("same_rvalid_clr", 32'(RVALID), 32'd0);
    RREADY = 0; BREADY = 0;
    model_write(32'h0C, 32'hF0F0F0F0, 4'hF);
    do_read(32'h0C, 0, 0, d, r);
    check("same_after_rdata", d, 32'hF0F0F0F0);

    for (int it = 0; it < 60; it++) begin
      addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r);
        check($sformatf("rnd%0d_bresp", it), 32'(r), model_mapped(addr) ? 32'd0 : 32'd3);
        model_write(addr, data, strb);
      end else begin
        do_read(addr, $urandom_range(0, 3), $urandom_range(0, 3), d, r);
        check($sformatf("rnd%0d_rresp", it), 32'(r), model_mapped(addr) ? 32'd0 : 32'd3);
        check($sformatf("rnd%0d_rdata", it), d, model_mapped(addr) ? model[addr / 4] : 32'd0);
      end
    end
    check_all_regs("rnd_regs");

    // Reset mid-write between edges: held AW is dropped, outputs clear without a clock.
    do_write(32'h00, 32'hA5A5A5A5, 4'hF, 0, 0, 0, r);
    AWADDR = 32'h10; AWVALID = 1;
    step();
    AWVALID = 0;
    check("mid_aw_held", 32'(AWREADY), 32'd0);
    #2;
    ARESETn = 0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge ACLK);
    ARESETn = 1;
    step();
    model_clear();
    WDATA = 32'h77777777; WSTRB = 4'hF; WVALID = 1;
    step();
    WVALID = 0;
    repeat (3) step();
    check("mid_no_commit", 32'(BVALID), 32'd0);
    AWADDR = 32'h14; AWVALID = 1; BREADY = 1;
    step();
    AWVALID = 0;
    step();
    check("mid_late_bvalid", 32'(BVALID), 32'd1);
    step();
    BREADY = 0;
    model_write(32'h14, 32'h77777777, 4'hF);
    check_all_regs("mid_regs");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite responder (slave) that terminates the five channels driven by the team's AXI-Lite master.
- Contains a bank of DEPTH 32-bit read/write registers with byte-strobe writes, independent AW/W acceptance and DECERR for unmapped addresses.
- Register 0 is also exported as a sideband output for board-level observation.

Parameters:
- WIDTH, 32, data and address width in bits (data width fixed at 32 for this block; address uses WIDTH bits).
- DEPTH, 8, number of 32-bit registers; power of two, 2..256.
- AW_IDX, $clog2(DEPTH), index bits taken from ADDR[AW_IDX+1:2] (derived, localparam).

Ports:
- ACLK  in  1  system clock, all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- AWADDR  in  WIDTH  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  WIDTH  write data.
- WSTRB  in  WIDTH/8  byte strobes; bit i enables WDATA[8i+7:8i].
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response (00 OKAY, 11 DECERR).
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  WIDTH  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  WIDTH  read data.
- RRESP  out  2  read response (00 OKAY, 11 DECERR).
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- reg0_out  out  WIDTH  live value of register 0.

Behaviour:
- Reset (ARESETn=0, asynchronous, takes effect without a clock edge):
  - All registers = 0; AWREADY=1, WREADY=1.
  - BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0, reg0_out=0.
  - Any held address/data is discarded; an in-flight transaction is silently dropped.
- Address decode:
  - Mapped when ADDR[1:0] are ignored, ADDR[AW_IDX+1:2] selects the register, and all bits ADDR[WIDTH-1:AW_IDX+2] = 0.
  - Otherwise the access is unmapped and returns DECERR.
- Write path (state per channel: EMPTY/HELD):
  - AWREADY = !aw_held; the AW handshake latches AWADDR and sets aw_held.
  - WREADY = !w_held; the W handshake latches WDATA/WSTRB and sets w_held.
  - AW and W are accepted in either order or in the same cycle; neither waits for the other.
  - Commit edge: first rising edge where aw_held && w_held && !BVALID.
    - Register bytes with WSTRB=1 are updated; bytes with WSTRB=0 are unchanged.
    - Both held flags clear; BVALID=1; BRESP=00 if mapped, else 11 with no register change.
  - WSTRB=0000 to a mapped address: no change, BRESP=00.
  - BVALID holds with stable BRESP until BREADY=1; it clears on the handshake edge.
  - While BVALID=1, new AW/W beats may be accepted into the held slots (one each) but do not commit until B completes.
  - Minimum latency: AW+W handshake at edge n gives commit at edge n+1; BVALID is visible after edge n+1.
- Read path (states IDLE/RESP):
  - ARREADY = !RVALID.
  - The AR handshake at edge n registers RDATA/RRESP and sets RVALID, visible after edge n (1-cycle latency).
  - Unmapped read: RDATA=0, RRESP=11.
  - RVALID, RDATA and RRESP are stable until RREADY=1; RVALID clears at the handshake edge.
  - Back-to-back reads are not supported in the same cycle as an R handshake, because ARREADY=0 while RVALID=1. Throughput is one read per 2 cycles.
- Simultaneous events:
  - A read and a write commit to the same register on the same edge: RDATA returns the pre-write value.
  - The read and write paths are otherwise fully independent.
- reg0_out is the register-0 flop output; it updates on the cycle after the commit.
- BRESP/RRESP values 01 and 10 are never generated.

Decomposition:
- Package axil_pkg:
  - resp_t (2-bit) with constants RESP_OKAY=2'b00, RESP_DECERR=2'b11.
  - Function byte_merge(old, new, strb).
- One natural sub-module: axil_reg_bank (DEPTH x 32 storage, byte-enable write port, one combinational read port, reg0 tap).
- The channel handshake logic stays in axil_reg_slave.

Test Plan:
- Reset, then AW=0x04 and W=0xDEADBEEF with strb=1111 in the same cycle, BREADY=1 -> BVALID after 2 edges, BRESP=00; read of 0x04 returns RDATA=0xDEADBEEF, RRESP=00.
- W (0x000000AA, strb=0001) issued 3 cycles before AW=0x00 -> WREADY drops after the W beat, commit occurs after AW; reg0_out=0x000000AA and upper bytes keep their prior values.
- Write 0x11223344 to 0x08, then strb=0100 with data 0x00FF0000 -> read of 0x08 = 0x11FF3344.
- Write to 0x40 (unmapped, DEPTH=8) -> BRESP=11 and no register changes; read of 0x40 -> RDATA=0, RRESP=11.
- Hold BREADY=0 for 5 cycles -> BVALID and BRESP stable, a second AW/W pair is accepted but not committed; after BREADY=1 the second BVALID follows.
- ARESETn pulsed low mid-write (aw_held=1) between clock edges -> all outputs return to reset values immediately, registers read back 0, and the held AW is not committed.
